// File: rtl/regfile_sched_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package regfile_sched_pkg;
  localparam int NREG         = 32;
  localparam int REG_AW       = 5;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 3;
  localparam int CNT_W        = 2;

  typedef logic [REG_AW-1:0] regn_t;
  typedef logic [DATA_W-1:0] data_t;

  // One-hot mask for register r; r0 maps to an empty mask so it is never tracked.
  function automatic logic [NREG-1:0] reg_mask(input regn_t r);
    reg_mask    = '0;
    reg_mask[r] = (r != '0);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-vector scoreboard: hazard check against same-cycle commit, busy set/clear, sticky error.
module regfile_scoreboard
  import regfile_sched_pkg::*;
(
  input  logic            clk,
  input  logic            clrn,
  input  logic            is_valid,
  input  regn_t           is_rs,
  input  regn_t           is_rt,
  input  regn_t           is_rd,
  input  logic            is_wr,
  input  logic            commit,
  input  regn_t           cwn,
  output logic            is_stall,
  output logic            idle,
  output logic            sb_err
);
  logic [NREG-1:0] busy, eff_busy, busy_nxt;
  logic            issue;

  // A register written back this cycle is already free for the issuing instruction.
  assign eff_busy = busy & ~(commit ? reg_mask(cwn) : {NREG{1'b0}});

  assign is_stall = clrn && is_valid &&
                    (eff_busy[is_rs] || eff_busy[is_rt] || (is_wr && eff_busy[is_rd]));
  assign issue    = is_valid && !is_stall && is_wr && (is_rd != '0);
  assign idle     = (busy == '0);

  // Clear first, then set: a same-cycle reissue of the committed register wins.
  always_comb begin
    busy_nxt = busy;
    if (commit) busy_nxt = busy_nxt & ~reg_mask(cwn);
    if (issue)  busy_nxt[is_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (commit && (cwn != '0) && !busy[cwn]) sb_err <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_sched.sv
// Writeback arbiter (pipeline port A vs multi-cycle port B) with starvation guard, plus scoreboard.
module regfile_sched
  import regfile_sched_pkg::*;
(
  input  logic  clk,
  input  logic  clrn,
  input  logic  is_valid,
  input  regn_t is_rs,
  input  regn_t is_rt,
  input  regn_t is_rd,
  input  logic  is_wr,
  output logic  is_stall,
  input  logic  a_valid,
  input  regn_t a_wn,
  input  data_t a_d,
  output logic  a_ready,
  input  logic  b_valid,
  input  regn_t b_wn,
  input  data_t b_d,
  output logic  b_ready,
  output logic  rf_we,
  output regn_t rf_wn,
  output data_t rf_d,
  output logic  idle,
  output logic  sb_err
);
  logic [CNT_W-1:0] cnt;
  logic             starve, a_com, b_com;

  // B has waited STARVE_LIMIT cycles: block A for one cycle so B drains.
  assign starve  = (cnt == CNT_W'(STARVE_LIMIT)) && b_valid;
  assign a_ready = clrn && !starve;
  assign b_ready = clrn && (starve || !a_valid);
  assign a_com   = a_valid && a_ready;
  assign b_com   = b_valid && b_ready;

  assign rf_we = a_com || b_com;
  assign rf_wn = a_com ? a_wn : b_wn;
  assign rf_d  = a_com ? a_d  : b_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                  cnt <= '0;
    else if (!b_valid || b_com) cnt <= '0;
    else if (cnt != CNT_W'(STARVE_LIMIT)) cnt <= cnt + CNT_W'(1);
  end

  regfile_scoreboard u_sb (
    .clk      (clk),
    .clrn     (clrn),
    .is_valid (is_valid),
    .is_rs    (is_rs),
    .is_rt    (is_rt),
    .is_rd    (is_rd),
    .is_wr    (is_wr),
    .commit   (rf_we),
    .cwn      (rf_wn),
    .is_stall (is_stall),
    .idle     (idle),
    .sb_err   (sb_err)
  );
endmodule

// File: tb/tb_regfile_sched.sv
// Directed bench for regfile_sched: hazards, commit forwarding, starvation, error flag, async reset.
module tb_regfile_sched;
  logic        clk = 1'b0, clrn;
  logic        is_valid, is_wr, is_stall;
  logic [4:0]  is_rs, is_rt, is_rd;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_wn, b_wn, rf_wn;
  logic [31:0] a_d, b_d, rf_d;
  logic        rf_we, idle, sb_err;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  regfile_sched dut (
    .clk(clk), .clrn(clrn),
    .is_valid(is_valid), .is_rs(is_rs), .is_rt(is_rt), .is_rd(is_rd), .is_wr(is_wr),
    .is_stall(is_stall),
    .a_valid(a_valid), .a_wn(a_wn), .a_d(a_d), .a_ready(a_ready),
    .b_valid(b_valid), .b_wn(b_wn), .b_d(b_d), .b_ready(b_ready),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d),
    .idle(idle), .sb_err(sb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    is_valid = 0; is_wr = 0; is_rs = 0; is_rt = 0; is_rd = 0;
    a_valid = 0; a_wn = 0; a_d = 0;
    b_valid = 0; b_wn = 0; b_d = 0;
  endtask

  // Inputs change on negedge; the following posedge commits them.
  task automatic nxt();
    @(negedge clk);
    quiet();
  endtask

  task automatic issue(input logic [4:0] rd);
    is_valid = 1; is_wr = 1; is_rd = rd;
  endtask

  task automatic probe(input string tag, input logic [4:0] r, input logic exp);
    is_valid = 1; is_wr = 0; is_rs = r; is_rt = 0; #1;
    chk(tag, 32'(is_stall), 32'(exp));
    is_valid = 0; is_rs = 0;
  endtask

  initial begin
    quiet();
    clrn = 0;
    // Reset: outputs forced even with live requests.
    is_valid = 1; is_rs = 5; a_valid = 1; a_wn = 3; b_valid = 1;
    #2;
    chk("rst_idle", 32'(idle), 1);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_stall", 32'(is_stall), 0);
    chk("rst_sb_err", 32'(sb_err), 0);
    nxt(); clrn = 1;

    // RAW hazard resolved by a same-cycle commit.
    nxt(); issue(5); #1; chk("iss5_stall", 32'(is_stall), 0);
    nxt(); is_valid = 1; is_rs = 5; #1; chk("raw5_stall", 32'(is_stall), 1);
    a_valid = 1; a_wn = 5; a_d = 32'h55; #1;
    chk("raw5_fwd_stall", 32'(is_stall), 0);
    chk("raw5_rf_we", 32'(rf_we), 1);
    chk("raw5_rf_wn", 32'(rf_wn), 5);
    chk("raw5_rf_d", rf_d, 32'h55);
    nxt(); #1; chk("raw5_idle", 32'(idle), 1);
    probe("raw5_free", 5, 0);
    chk("raw5_sb_err", 32'(sb_err), 0);

    // Commit and reissue of r7 in one cycle: set wins.
    nxt(); issue(7);
    nxt(); issue(7); a_valid = 1; a_wn = 7; a_d = 32'h77; #1;
    chk("r7_stall", 32'(is_stall), 0);
    chk("r7_rf_we", 32'(rf_we), 1);
    nxt(); #1;
    chk("r7_idle", 32'(idle), 0);
    chk("r7_sb_err", 32'(sb_err), 0);
    probe("r7_busy", 7, 1);
    nxt(); a_valid = 1; a_wn = 7;
    nxt(); #1; chk("r7_drain_idle", 32'(idle), 1);

    // r0: issue ignored, commit forwarded.
    nxt(); issue(0); a_valid = 1; a_wn = 0; a_d = 32'hAB; #1;
    chk("r0_stall", 32'(is_stall), 0);
    chk("r0_rf_we", 32'(rf_we), 1);
    chk("r0_rf_wn", 32'(rf_wn), 0);
    chk("r0_rf_d", rf_d, 32'hAB);
    nxt(); #1;
    chk("r0_idle", 32'(idle), 1);
    chk("r0_sb_err", 32'(sb_err), 0);

    // B alone is granted immediately.
    nxt(); b_valid = 1; b_d = 32'hB0; #1;
    chk("bsolo_b_ready", 32'(b_ready), 1);
    chk("bsolo_rf_d", rf_d, 32'hB0);

    // Contention: A wins three cycles, B forced on the fourth, counter then back to 0.
    for (int i = 1; i <= 5; i++) begin
      nxt(); a_valid = 1; a_d = 32'hA0 + 32'(i); b_valid = 1; b_d = 32'hB0 + 32'(i); #1;
      if (i == 4) begin
        chk("starve_a_ready", 32'(a_ready), 0);
        chk("starve_b_ready", 32'(b_ready), 1);
        chk("starve_rf_d", rf_d, 32'hB4);
      end else begin
        chk($sformatf("cont%0d_a_ready", i), 32'(a_ready), 1);
        chk($sformatf("cont%0d_b_ready", i), 32'(b_ready), 0);
        chk($sformatf("cont%0d_rf_d", i), rf_d, 32'hA0 + 32'(i));
      end
    end

    // A gap in b_valid restarts the wait count.
    for (int i = 1; i <= 5; i++) begin
      nxt(); a_valid = 1; b_valid = (i != 3); #1;
      chk($sformatf("gap%0d_a_ready", i), 32'(a_ready), 1);
    end

    // Commit to a free register: write proceeds, error sticks until reset.
    nxt(); a_valid = 1; a_wn = 9; a_d = 32'h99; #1;
    chk("err9_rf_we", 32'(rf_we), 1);
    chk("err9_pre", 32'(sb_err), 0);
    nxt(); #1; chk("err9_set", 32'(sb_err), 1);
    nxt(); #1; chk("err9_hold", 32'(sb_err), 1);

    // Async reset mid-operation with busy = 0xF0.
    for (int r = 4; r <= 7; r++) begin nxt(); issue(5'(r)); end
    nxt(); #1; chk("f0_idle", 32'(idle), 0);
    a_valid = 1; a_wn = 4; #1; chk("f0_rf_we", 32'(rf_we), 1);
    #1 clrn = 0; #1;
    chk("arst_rf_we", 32'(rf_we), 0);
    chk("arst_idle", 32'(idle), 1);
    chk("arst_sb_err", 32'(sb_err), 0);
    chk("arst_a_ready", 32'(a_ready), 0);
    @(negedge clk); clrn = 1; quiet(); #1;
    chk("post_idle", 32'(idle), 1);
    chk("post_sb_err", 32'(sb_err), 0);
    probe("post_r4_free", 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sched.md
REGFILE_SCHED -- requirements
Module: regfile_sched

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have ports: clrn  in  1  asynchronous active-low reset.
REQ-003 SHALL have issue ports: is_valid in 1; is_rs, is_rt, is_rd in 5 each; is_wr in 1 (instruction writes is_rd); is_stall out 1.
REQ-004 SHALL have writeback port A (pipeline): a_valid in 1, a_wn in 5, a_d in 32, a_ready out 1.
REQ-005 SHALL have writeback port B (multi-cycle unit): b_valid in 1, b_wn in 5, b_d in 32, b_ready out 1.
REQ-006 SHALL drive the register-file write port: rf_we out 1, rf_wn out 5, rf_d out 32.
REQ-007 SHALL output idle (1; no register pending) and sb_err (1; sticky scoreboard error).

Function
REQ-008 SHALL hold a 32-bit busy vector; bit 0 is never set.
REQ-009 SHALL define commit as (a_valid && a_ready) or (b_valid && b_ready); at most one commit per cycle.
REQ-010 SHALL drive rf_we = commit, rf_wn/rf_d = winning port's wn/d, combinationally in the same cycle (zero latency; the register file writes on negedge).
REQ-011 SHALL grant A by default: a_ready = 1, b_ready = !a_valid, unless starvation applies.
REQ-012 SHALL count consecutive cycles in which b_valid is high and B is not granted (2-bit counter, saturating at STARVE_LIMIT = 3).
REQ-013 SHALL, when the counter equals STARVE_LIMIT and b_valid is high, force b_ready = 1 and a_ready = 0; A holds its payload until accepted.
REQ-014 SHALL clear the starvation counter on any B commit or when b_valid is low.
REQ-015 SHALL compute eff_busy = busy with the bit for the same-cycle commit wn cleared.
REQ-016 SHALL assert is_stall = is_valid && (eff_busy[is_rs] || eff_busy[is_rt] || (is_wr && eff_busy[is_rd])); r0 is never busy.
REQ-017 SHALL, on posedge with issue accepted (is_valid && !is_stall && is_wr && is_rd != 0), set busy[is_rd].
REQ-018 SHALL, on posedge with commit and wn != 0, clear busy[wn].
REQ-019 SHALL give set priority over clear when the same register is committed and issued in one cycle.
REQ-020 SHALL set sb_err when a commit targets a non-zero register whose busy bit is 0; it holds until reset, and the write still proceeds.
REQ-021 SHALL forward a commit with wn = 0 to the write port (rf_we = 1) without touching busy.
REQ-022 SHALL drive idle = (busy == 0), registered view (current busy state).

Reset
REQ-023 SHALL, while clrn = 0, clear busy, the starvation counter and sb_err, and force rf_we = 0, a_ready = 0, b_ready = 0 and is_stall = 0; idle = 1.
REQ-024 SHALL drop in-flight writebacks presented during reset; normal operation resumes on the first posedge after clrn rises.

Structure
REQ-025 SHALL place NREG = 32, REG_AW = 5 and STARVE_LIMIT = 3 in the shared package regfile_sched_pkg.
REQ-026 SHALL implement the busy vector, hazard check and sb_err in the sub-module regfile_scoreboard; arbitration stays in regfile_sched.

Verification
REQ-027 SHALL cover: issue rd=5 (is_wr), next cycle issue rs=5 -> is_stall=1; A commits wn=5 that cycle -> is_stall=0 in the same cycle, busy[5]=0 next.
REQ-028 SHALL cover: a_valid and b_valid both high for 4 cycles -> A wins cycles 1-3, cycle 4 b_ready=1, a_ready=0, rf_wn=b_wn, counter returns to 0.
REQ-029 SHALL cover: commit wn=7 and issue rd=7 in the same cycle -> busy[7]=1 afterwards, sb_err=0.
REQ-030 SHALL cover: commit wn=9 with busy[9]=0 -> rf_we=1 and sb_err=1 from next cycle until clrn pulses low.
REQ-031 SHALL cover: issue rd=0 and commit wn=0 -> busy unchanged, idle=1, rf_we=1 with rf_wn=0.
REQ-032 SHALL cover: clrn low mid-operation with busy=0x0000_00F0 -> busy=0, idle=1 and rf_we=0 immediately, with no clock edge.
